seq_bin2bcd: RTL

- Iterative shift-add-3 (double-dabble) converter from a binary word to packed BCD digits.
- Sits downstream of the CPU result tap: the 16-bit half-word select of r2. Feeds the per-digit 7-segment decoders and the digit-multiplex logic.
- Replaces the combinational divide/modulo converter; uses one add-3/shift step per clock.
- Holds the last result stable during conversion, so the display does not flicker.

---
 rtl/seq_bin2bcd.sv | 137 +++++++++++++
 1 files changed

// File: rtl/seq_bin2bcd.sv
// Sequential binary-to-BCD converter using double-dabble, one add-3/shift step per clock.
// The displayed result, blank mask and overflow flag only change when a conversion completes.
module seq_bin2bcd #(
  parameter int WIDTH       = 16,
  parameter int DIGITS      = 5,
  parameter int DISP_DIGITS = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic                  auto_en,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank,
  output logic                  ovf
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {IDLE, CONV, LATCH} state_t;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      shift_q, shift_d;
  logic [WIDTH-1:0]      last_q, last_d;
  logic [4*DIGITS-1:0]   scratch_q, scratch_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic [DIGITS-1:0]     blank_q, blank_d;
  logic                  ovf_q, ovf_d;

  logic [4*DIGITS-1:0]   adj;
  logic [DIGITS-1:0]     blank_n;
  logic                  ovf_n;
  logic                  zero_above;
  logic                  trigger;

  // Nibbles never exceed 9 before the add, so the 4-bit add cannot carry out.
  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    blank_n    = '0;
    ovf_n      = 1'b0;
    zero_above = 1'b1;
    for (int i = DIGITS-1; i >= 0; i--) begin
      zero_above = zero_above & (scratch_q[4*i +: 4] == 4'd0);
      blank_n[i] = zero_above;
    end
    blank_n[0] = 1'b0;
    for (int i = DISP_DIGITS; i < DIGITS; i++) begin
      ovf_n = ovf_n | (|scratch_q[4*i +: 4]);
    end
  end

  assign trigger = start | (auto_en & (bin_in != last_q));

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    last_d    = last_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    bcd_d     = bcd_q;
    blank_d   = blank_q;
    ovf_d     = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          shift_d   = bin_in;
          last_d    = bin_in;
          scratch_d = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = CONV;
        end
      end
      CONV: begin
        {scratch_d, shift_d} = {adj[4*DIGITS-2:0], shift_q, 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH-1)) state_d = LATCH;
      end
      LATCH: begin
        bcd_d   = scratch_q;
        blank_d = blank_n;
        ovf_d   = ovf_n;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      last_q    <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
      blank_q   <= BLANK_RST;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      last_q    <= last_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bcd_q     <= bcd_d;
      blank_q   <= blank_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;
  assign blank   = blank_q;
  assign ovf     = ovf_q;

endmodule
